alu_mc: RTL and testbench

Parametrised multi-cycle successor to the single-cycle 32-bit ALU. It keeps the ADD/SUB/AND/OR/SLL/SRA opcode set and the compare/overflow flags, and adds signed iterative MUL and DIV. Operand acceptance and result delivery use valid/ready handshakes. It sits between operand fetch and writeback in the processor datapath, and it stalls issue while busy.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_muldiv_iter.sv | 106 ++++++++++
 rtl/alu_mc.sv | 189 ++++++++++++++++++
 tb/tb_alu_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode field, opcode values,
// FSM state encoding and small opcode-classification helpers.
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
    localparam logic [OP_W-1:0] OP_SRA = 5'b00101;
    localparam logic [OP_W-1:0] OP_MUL = 5'b00110;
    localparam logic [OP_W-1:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Opcodes that need the iterative datapath.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Only the low eight encodings carry an operation.
    function automatic logic is_defined(input logic [OP_W-1:0] op);
        return (op[OP_W-1:3] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative datapath: shift-add multiply and restoring divide on
// operand magnitudes, one bit per step, with the sign applied on the last step.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             mode_i,      // 0: multiply, 1: divide
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             mul_ovf_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   acc_q, acc_d;     // product high half / remainder
    logic [WIDTH-1:0]   sr_q, sr_d;       // multiplier bits / quotient bits
    logic [WIDTH-1:0]   mag_b_q, mag_b_d; // multiplicand / divisor magnitude
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               mode_q, mode_d;

    logic [WIDTH-1:0]   mag_a_s, mag_b_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH+1:0]   sub_s;
    logic [2*WIDTH-1:0] prod_mag_s, prod_s;
    logic [WIDTH:0]     prod_hi_s;
    logic [WIDTH-1:0]   quo_s;

    // Operand magnitudes; |MIN| still fits as an unsigned WIDTH-bit value.
    always_comb begin
        mag_a_s = a_i[WIDTH-1] ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;
        mag_b_s = b_i[WIDTH-1] ? (~b_i + {{(WIDTH-1){1'b0}}, 1'b1}) : b_i;
    end

    // Load on start, otherwise advance one multiply or divide step.
    always_comb begin
        acc_d   = acc_q;
        sr_d    = sr_q;
        mag_b_d = mag_b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        mode_d  = mode_q;
        add_s   = {1'b0, acc_q} + {1'b0, (sr_q[0] ? mag_b_q : {WIDTH{1'b0}})};
        shl_s   = {acc_q, sr_q[WIDTH-1]};
        sub_s   = {1'b0, shl_s} - {2'b00, mag_b_q};
        if (start_i) begin
            acc_d   = {WIDTH{1'b0}};
            sr_d    = mag_a_s;
            mag_b_d = mag_b_s;
            cnt_d   = CNT_W'(WIDTH);
            neg_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            mode_d  = mode_i;
        end else if (step_i) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (!mode_q) begin
                acc_d = add_s[WIDTH:1];
                sr_d  = {add_s[0], sr_q[WIDTH-1:1]};
            end else if (!sub_s[WIDTH+1]) begin
                acc_d = sub_s[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shl_s[WIDTH-1:0];
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Final signed result formed from the values the last step produces.
    always_comb begin
        prod_mag_s = {acc_d, sr_d};
        prod_s     = neg_q ? (~prod_mag_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : prod_mag_s;
        prod_hi_s  = prod_s[2*WIDTH-1:WIDTH-1];
        quo_s      = neg_q ? (~sr_d + {{(WIDTH-1){1'b0}}, 1'b1}) : sr_d;
        done_o     = step_i && (cnt_q == CNT_W'(1));
        result_o   = mode_q ? quo_s : prod_s[WIDTH-1:0];
        mul_ovf_o  = !mode_q && !((&prod_hi_s) || !(|prod_hi_s));
    end

    // Iteration state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q   <= {WIDTH{1'b0}};
            sr_q    <= {WIDTH{1'b0}};
            mag_b_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            neg_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            mag_b_q <= mag_b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/SLL/SRA, iterative signed
// MUL/DIV, compare/overflow flags, valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               div_by_zero
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, dbz_q, dbz_d;

    logic              idle_s, fire_s;
    logic [WIDTH-1:0]  opa_s, opb_s, sum_s, diff_s, single_res_s;
    logic              add_ovf_s, sub_ovf_s, single_ovf_s, ne_s, lt_s;
    logic              b_zero_s, div_ovf_s;
    logic              iter_done_s, iter_mul_ovf_s;
    logic [WIDTH-1:0]  iter_result_s;

    // Flags use the live inputs at transfer and the captured operands later.
    always_comb begin
        idle_s       = (state_q == IDLE);
        fire_s       = idle_s && in_valid;
        opa_s        = idle_s ? data_operandA : a_q;
        opb_s        = idle_s ? data_operandB : b_q;
        sum_s        = opa_s + opb_s;
        diff_s       = opa_s - opb_s;
        add_ovf_s    = (opa_s[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
        sub_ovf_s    = (opa_s[WIDTH-1] != opb_s[WIDTH-1]) && (diff_s[WIDTH-1] != opa_s[WIDTH-1]);
        ne_s         = (opa_s != opb_s);
        lt_s         = diff_s[WIDTH-1] ^ sub_ovf_s;
        b_zero_s     = (opb_s == {WIDTH{1'b0}});
        div_ovf_s    = (opa_s == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_s == {WIDTH{1'b1}});
    end

    // Single-cycle operation results.
    always_comb begin
        single_res_s = {WIDTH{1'b0}};
        single_ovf_s = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin
                single_res_s = sum_s;
                single_ovf_s = add_ovf_s;
            end
            OP_SUB: begin
                single_res_s = diff_s;
                single_ovf_s = sub_ovf_s;
            end
            OP_AND:  single_res_s = opa_s & opb_s;
            OP_OR:   single_res_s = opa_s | opb_s;
            OP_SLL:  single_res_s = opa_s << ctrl_shiftamt;
            OP_SRA:  single_res_s = $signed(opa_s) >>> ctrl_shiftamt;
            default: single_res_s = {WIDTH{1'b0}};
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i     (clock),
        .rst_i     (reset),
        .start_i   (fire_s && is_muldiv(ctrl_ALUopcode)),
        .step_i    (state_q == BUSY),
        .mode_i    (ctrl_ALUopcode == OP_DIV),
        .a_i       (data_operandA),
        .b_i       (data_operandB),
        .done_o    (iter_done_s),
        .result_o  (iter_result_s),
        .mul_ovf_o (iter_mul_ovf_s)
    );

    // Next-state, capture and result/flag update for the three-state FSM.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ne_d     = ne_q;
        lt_d     = lt_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (fire_s) begin
                    op_d = ctrl_ALUopcode;
                    a_d  = data_operandA;
                    b_d  = data_operandB;
                    if (is_muldiv(ctrl_ALUopcode)) begin
                        state_d = BUSY;
                    end else if (is_defined(ctrl_ALUopcode)) begin
                        state_d  = DONE;
                        result_d = single_res_s;
                        ne_d     = ne_s;
                        lt_d     = lt_s;
                        ovf_d    = single_ovf_s;
                        dbz_d    = 1'b0;
                    end else begin
                        state_d  = DONE;
                        result_d = {WIDTH{1'b0}};
                        ne_d     = 1'b0;
                        lt_d     = 1'b0;
                        ovf_d    = 1'b0;
                        dbz_d    = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (iter_done_s) begin
                    state_d = DONE;
                    ne_d    = ne_s;
                    lt_d    = lt_s;
                    if (op_q == OP_DIV) begin
                        result_d = b_zero_s ? {WIDTH{1'b0}} : iter_result_s;
                        ovf_d    = div_ovf_s;
                        dbz_d    = b_zero_s;
                    end else begin
                        result_d = iter_result_s;
                        ovf_d    = iter_mul_ovf_s;
                        dbz_d    = 1'b0;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= {OP_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign data_result = result_q;
    assign isNotEqual  = ne_q;
    assign isLessThan  = lt_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance driven with directed and
// random operations, checked against an integer-arithmetic reference model.
module tb_alu_mc;

    logic        clk, rst;

    logic        iv32, ir32, ov32, ordy32, ne32, lt32, ovf32, dbz32;
    logic [4:0]  op32, sh32;
    logic [31:0] a32, b32, res32;

    logic        iv8, ir8, ov8, ordy8, ne8, lt8, ovf8, dbz8;
    logic [4:0]  op8;
    logic [2:0]  sh8;
    logic [7:0]  a8, b8, res8;

    bit          cur8;
    logic        obs_valid, obs_ready, obs_ne, obs_lt, obs_ovf, obs_dbz;
    logic [31:0] obs_res;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ovf;
        logic        dbz;
    } exp_t;

    alu_mc #(.WIDTH(32)) dut32 (
        .clock(clk), .reset(rst), .in_valid(iv32), .in_ready(ir32),
        .ctrl_ALUopcode(op32), .ctrl_shiftamt(sh32),
        .data_operandA(a32), .data_operandB(b32),
        .out_valid(ov32), .out_ready(ordy32), .data_result(res32),
        .isNotEqual(ne32), .isLessThan(lt32), .overflow(ovf32), .div_by_zero(dbz32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clock(clk), .reset(rst), .in_valid(iv8), .in_ready(ir8),
        .ctrl_ALUopcode(op8), .ctrl_shiftamt(sh8),
        .data_operandA(a8), .data_operandB(b8),
        .out_valid(ov8), .out_ready(ordy8), .data_result(res8),
        .isNotEqual(ne8), .isLessThan(lt8), .overflow(ovf8), .div_by_zero(dbz8)
    );

    assign obs_valid = cur8 ? ov8  : ov32;
    assign obs_ready = cur8 ? ir8  : ir32;
    assign obs_res   = cur8 ? {24'd0, res8} : res32;
    assign obs_ne    = cur8 ? ne8  : ne32;
    assign obs_lt    = cur8 ? lt8  : lt32;
    assign obs_ovf   = cur8 ? ovf8 : ovf32;
    assign obs_dbz   = cur8 ? dbz8 : dbz32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: operate on true signed integers, then truncate to w bits.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int sh, input int w);
        exp_t e;
        longint sa, sb, mn, mx, r;
        longint unsigned mask;
        e    = '0;
        mask = (64'd1 << w) - 64'd1;
        mn   = -(64'sd1 <<< (w - 1));
        mx   = (64'sd1 <<< (w - 1)) - 64'sd1;
        sa   = $signed({32'd0, a} & mask);
        sb   = $signed({32'd0, b} & mask);
        if (a[w-1]) sa = sa - (64'sd1 <<< w);
        if (b[w-1]) sb = sb - (64'sd1 <<< w);
        if (op > 5'd7) return e;
        e.ne = (sa != sb);
        e.lt = (sa < sb);
        r = 64'sd0;
        case (op)
            5'd0: begin r = sa + sb; e.ovf = (r > mx) || (r < mn); end
            5'd1: begin r = sa - sb; e.ovf = (r > mx) || (r < mn); end
            5'd2: r = sa & sb;
            5'd3: r = sa | sb;
            5'd4: r = sa << sh;
            5'd5: r = sa >>> sh;
            5'd6: begin r = sa * sb; e.ovf = (r > mx) || (r < mn); end
            default: begin
                if (sb == 64'sd0) begin
                    r = 64'sd0;
                    e.dbz = 1'b1;
                end else if (sa == mn && sb == -64'sd1) begin
                    r = mn;
                    e.ovf = 1'b1;
                end else begin
                    r = sa / sb;
                end
            end
        endcase
        e.res = r[31:0] & mask[31:0];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: transfer, latency measurement, result/flags, hold, drain.
    task automatic run_op(input bit w8, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int sh, input int hold, input string tag);
        exp_t e;
        int   w, lat, exp_lat;
        w       = w8 ? 8 : 32;
        e       = model(op, a, b, sh, w);
        exp_lat = (op == 5'd6 || op == 5'd7) ? w + 1 : 1;
        cur8    = w8;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, {31'd0, obs_ready}, 32'd1);
        if (w8) begin
            iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = sh[2:0];
        end else begin
            iv32 = 1'b1; op32 = op; a32 = a; b32 = b; sh32 = sh[4:0];
        end
        @(negedge clk);
        iv8 = 1'b0; iv32 = 1'b0;
        op8 = ~op8; op32 = ~op32; a8 = ~a8; b8 = ~b8; a32 = ~a32; b32 = ~b32;
        lat = 1;
        while (!obs_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, obs_res, e.res);
        check({tag, "_ne"}, {31'd0, obs_ne}, {31'd0, e.ne});
        check({tag, "_lt"}, {31'd0, obs_lt}, {31'd0, e.lt});
        check({tag, "_ovf"}, {31'd0, obs_ovf}, {31'd0, e.ovf});
        check({tag, "_dbz"}, {31'd0, obs_dbz}, {31'd0, e.dbz});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, obs_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, obs_ready}, 32'd0);
            check({tag, "_hold_result"}, obs_res, e.res);
        end
        ordy8 = 1'b1; ordy32 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0; ordy32 = 1'b0;
        check({tag, "_drained_valid"}, {31'd0, obs_valid}, 32'd0);
        check({tag, "_drained_ready"}, {31'd0, obs_ready}, 32'd1);
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1 << (w - 1);
            4: v = (32'd1 << (w - 1)) - 32'd1;
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'd1 << w) - 32'd1);
        return v;
    endfunction

    // Global time limit so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL timeout no summary reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [4:0] rop;
        iv32 = 1'b0; ordy32 = 1'b0; op32 = 5'd0; sh32 = 5'd0; a32 = 32'd0; b32 = 32'd0;
        iv8  = 1'b0; ordy8  = 1'b0; op8  = 5'd0; sh8  = 3'd0; a8  = 8'd0;  b8  = 8'd0;
        cur8 = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready32", {31'd0, ir32}, 32'd1);
        check("rst_out_valid32", {31'd0, ov32}, 32'd0);
        check("rst_result32", res32, 32'd0);
        check("rst_flags32", {28'd0, ne32, lt32, ovf32, dbz32}, 32'd0);
        check("rst_in_ready8", {31'd0, ir8}, 32'd1);
        check("rst_out_valid8", {31'd0, ov8}, 32'd0);
        rst = 1'b0;

        run_op(1'b0, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, "add_ovf");
        run_op(1'b0, 5'd1, 32'h8000_0001, 32'h7FFF_FFFF, 0, 0, "sub_ovf");
        run_op(1'b0, 5'd6, 32'hFFFF_FFFD, 32'd7, 0, 5, "mul_m3x7");
        run_op(1'b0, 5'd7, 32'd7, 32'd0, 0, 0, "div_by0");
        run_op(1'b0, 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_min_m1");
        run_op(1'b0, 5'd7, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
        run_op(1'b0, 5'd4, 32'h0000_0001, 32'd0, 31, 0, "sll_31");
        run_op(1'b0, 5'd5, 32'h8000_0000, 32'd0, 31, 0, "sra_31");
        run_op(1'b0, 5'd13, 32'd5, 32'd9, 0, 0, "undef");
        run_op(1'b1, 5'd5, 32'h80, 32'd0, 3, 0, "w8_sra");
        run_op(1'b1, 5'd6, 32'h10, 32'h10, 0, 2, "w8_mul_ovf");

        // Reset in the middle of a multiply aborts it.
        cur8 = 1'b0;
        @(negedge clk);
        iv32 = 1'b1; op32 = 5'd6; a32 = 32'd12345; b32 = 32'd678;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, ov32}, 32'd0);
        check("midrst_in_ready", {31'd0, ir32}, 32'd1);
        check("midrst_result", res32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 5'd0, 32'd2, 32'd2, 0, 0, "add_after_rst");

        for (int i = 0; i < 60; i++) begin
            rop = 5'($urandom_range(0, 9));
            if (rop > 5'd7) rop = 5'($urandom_range(8, 31));
            run_op(1'b0, rop, pick(32), pick(32), $urandom_range(0, 31),
                   $urandom_range(0, 2), "rand32");
        end
        for (int i = 0; i < 40; i++) begin
            rop = 5'($urandom_range(0, 9));
            if (rop > 5'd7) rop = 5'($urandom_range(8, 31));
            run_op(1'b1, rop, pick(8), pick(8), $urandom_range(0, 7),
                   $urandom_range(0, 2), "rand8");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
